conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_line_buffer.sv | 36 +++
 rtl/conv_window_gen.sv | 159 +++++++++++++++
 tb/tb_conv_window_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the sliding-window generator: FSM states, default
// pixel width and the window element-index mapping.
package conv_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } conv_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    // Element position inside the flattened window: channel-major, then row, then column.
    function automatic int unsigned win_elem_idx(input int unsigned d,
                                                 input int unsigned r,
                                                 input int unsigned c,
                                                 input int unsigned f);
        return d * f * f + r * f + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel delay line: the output is the pixel written DEPTH accepted writes ago.
module conv_line_buffer #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (we_i) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    // Storage is never cleared; every slot is rewritten before it is read back.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[ptr_q] <= din_i;
    end

    assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order F x F x D sliding-window generator (stride 1, no padding).
// Optional macro CONV_WIN_CNT_EN adds the per-frame win_count output.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned D          = 1,
    parameter int unsigned F          = 2,
    parameter int unsigned W          = 8,
    parameter int unsigned H          = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [D*DATA_WIDTH-1:0]         pix_data,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    output logic [0:D*F*F*DATA_WIDTH-1]     window,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic                            frame_done
`ifdef CONV_WIN_CNT_EN
    ,
    output logic [15:0]                     win_count
`endif
);

    localparam int unsigned PW = D * DATA_WIDTH;
    localparam int unsigned XW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned YW = (H > 1) ? $clog2(H) : 1;
    localparam logic [XW-1:0] X_LAST      = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(H - 1);
    localparam logic [XW-1:0] X_FIRST     = XW'(F - 1);
    localparam logic [YW-1:0] Y_FIRST     = YW'(F - 1);
    localparam logic [YW-1:0] Y_FILL_LAST = YW'((F > 1) ? F - 2 : 0);

    conv_state_e   state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;
    logic [PW-1:0] patch_q [F][F];
    logic [PW-1:0] col_in  [F];
    logic          accept, handoff, produce, last_pix;

    assign accept   = pix_valid && pix_ready;
    assign handoff  = win_valid_q && win_ready;
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
    assign produce  = accept && (x_q >= X_FIRST) && (y_q >= Y_FIRST);

    // Bottom patch row takes the live pixel; each line buffer feeds the row above it.
    assign col_in[F-1] = pix_data;
    for (genvar k = 1; k < F; k++) begin : g_lb
        conv_line_buffer #(
            .DW    (PW),
            .DEPTH (W)
        ) u_lb (
            .clk_i  (clk),
            .rst_ni (reset),
            .we_i   (accept),
            .din_i  (col_in[F-k]),
            .dout_o (col_in[F-1-k])
        );
    end

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        win_valid_d  = win_valid_q && !win_ready;
        frame_done_d = frame_done_q && !win_ready;
        if (accept) begin
            x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
            if (x_q == X_LAST) y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end
        if (produce) begin
            win_valid_d  = 1'b1;
            frame_done_d = last_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q          <= '0;
            y_q          <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int unsigned r = 0; r < F; r++)
                for (int unsigned c = 0; c < F; c++)
                    patch_q[r][c] <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (accept) begin
                for (int unsigned r = 0; r < F; r++) begin
                    for (int unsigned c = 0; c + 1 < F; c++)
                        patch_q[r][c] <= patch_q[r][c+1];
                    patch_q[r][F-1] <= col_in[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (F == 1) state_d = S_RUN;
                else if (accept && (y_q == Y_FILL_LAST) && (x_q == X_LAST)) state_d = S_RUN;
            end
            S_RUN: begin
                if (handoff && frame_done_q)       state_d = S_FILL;
                else if (win_valid_q && !win_ready) state_d = S_STALL;
            end
            S_STALL: begin
                if (win_ready) state_d = frame_done_q ? S_FILL : S_RUN;
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        pix_ready  = reset && (!win_valid_q || win_ready);
        win_valid  = reset && win_valid_q;
        frame_done = reset && frame_done_q;
        window     = '0;
        if (reset) begin
            for (int unsigned d = 0; d < D; d++)
                for (int unsigned r = 0; r < F; r++)
                    for (int unsigned c = 0; c < F; c++)
                        window[DATA_WIDTH*win_elem_idx(d, r, c, F) +: DATA_WIDTH] =
                            patch_q[r][c][(D-1-d)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef CONV_WIN_CNT_EN
    logic [15:0] win_count_q;
    logic        done_seen_q;

    // The handoff after a frame's last window restarts the count at 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_count_q <= '0;
            done_seen_q <= 1'b0;
        end else if (handoff) begin
            win_count_q <= done_seen_q ? 16'd1 : win_count_q + 16'd1;
            done_seen_q <= frame_done_q;
        end
    end

    assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed and randomized checks of conv_window_gen (W=H=4, F=2, D=1) against
// an image-array reference model.
module tb_conv_window_gen;

    localparam int DW = 16;
    localparam int D  = 1;
    localparam int F  = 2;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WN = D * F * F * DW;

    logic                clk;
    logic                reset;
    logic [D*DW-1:0]     pix_data;
    logic                pix_valid;
    logic                pix_ready;
    logic [0:WN-1]       window;
    logic                win_valid;
    logic                win_ready;
    logic                frame_done;
`ifdef CONV_WIN_CNT_EN
    logic [15:0]         win_count;
`endif

    conv_window_gen #(
        .DATA_WIDTH (DW),
        .D          (D),
        .F          (F),
        .W          (W),
        .H          (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .window     (window),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
`ifdef CONV_WIN_CNT_EN
        ,
        .win_count  (win_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int dut_hand = 0;
    int done_pulses = 0;

    // Reference model: the current frame as an image array plus the pending window.
    logic [DW-1:0] img [H][W];
    int            ex, ey;
    bit            m_valid, m_done;
    logic [0:WN-1] m_win;
    int            m_cnt;
    bit            m_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    // Drive one cycle at the falling edge, check the outputs, then advance the model.
    task automatic tick(input bit v, input logic [DW-1:0] data, input bit rdy, input bit rst);
        bit exp_ready, acc, hand;
        @(negedge clk);
        pix_valid = v;
        pix_data  = data;
        win_ready = rdy;
        reset     = rst;
        #1;
        exp_ready = rst && (!m_valid || rdy);
        check("pix_ready", 64'(pix_ready), 64'(exp_ready));
        check("win_valid", 64'(win_valid), 64'(rst && m_valid));
        check("frame_done", 64'(frame_done), 64'(rst && m_done));
        if (!rst)         check("window_in_reset", window, '0);
        else if (m_valid) check("window", window, m_win);
`ifdef CONV_WIN_CNT_EN
        if (rst) check("win_count", 64'(win_count), 64'(m_cnt));
`endif
        if (win_valid && win_ready) begin
            dut_hand++;
            if (frame_done) done_pulses++;
        end
        if (!rst) begin
            m_valid = 0; m_done = 0; ex = 0; ey = 0; m_cnt = 0; m_seen = 0;
        end else begin
            acc  = v && exp_ready;
            hand = m_valid && rdy;
            if (hand) begin
                m_cnt   = m_seen ? 1 : m_cnt + 1;
                m_seen  = m_done;
                m_valid = 0;
                m_done  = 0;
            end
            if (acc) begin
                img[ey][ex] = data;
                if (ey >= F - 1 && ex >= F - 1) begin
                    m_valid = 1;
                    m_done  = (ey == H - 1) && (ex == W - 1);
                    for (int r = 0; r < F; r++)
                        for (int c = 0; c < F; c++)
                            m_win[DW*(r*F+c) +: DW] = img[ey-F+1+r][ex-F+1+c];
                end
                ex++;
                if (ex == W) begin
                    ex = 0;
                    ey = (ey == H - 1) ? 0 : ey + 1;
                end
            end
        end
    endtask

    task automatic after_edge_window(input string tag, input logic [63:0] exp, input bit exp_done);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(win_valid), 64'(1));
        check(tag, window, exp);
        check({tag, "_done"}, 64'(frame_done), 64'(exp_done));
    endtask

    initial begin
        reset = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b0;
        ex = 0; ey = 0; m_valid = 0; m_done = 0; m_win = '0; m_cnt = 0; m_seen = 0;

        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);

        // Basic window and full frame
        for (int k = 1; k <= 16; k++) begin
            tick(1, 16'(k), 1, 1);
            if (k == 6)  after_edge_window("first_win", pack4(1, 2, 5, 6), 0);
            if (k == 16) after_edge_window("last_win", pack4(11, 12, 15, 16), 1);
        end
        tick(0, 0, 1, 1);
        check("frameA_windows", 64'(dut_hand), 64'(9));
        check("frameA_done_pulses", 64'(done_pulses), 64'(1));
`ifdef CONV_WIN_CNT_EN
        check("frameA_win_count", 64'(win_count), 64'(9));
`endif

        // Backpressure on window {2,3,6,7}
        dut_hand = 0;
        for (int k = 1; k <= 7; k++) tick(1, 16'(k), 1, 1);
        for (int s = 0; s < 3; s++) begin
            tick(1, 16'(8), 0, 1);
            check("bp_window", window, pack4(2, 3, 6, 7));
            check("bp_pix_ready", 64'(pix_ready), 64'(0));
        end
        for (int k = 8; k <= 16; k++) begin
            tick(1, 16'(k), 1, 1);
            if (k == 8) after_edge_window("bp_next_win", pack4(3, 4, 7, 8), 0);
        end
        tick(0, 0, 1, 1);
        check("frameB_windows", 64'(dut_hand), 64'(9));

        // Reset after 7 pixels, then a fresh frame
        for (int k = 1; k <= 7; k++) tick(1, 16'(k), 1, 1);
        tick(1, 16'(99), 1, 0);
        for (int k = 1; k <= 16; k++) begin
            tick(1, 16'(k), 1, 1);
            if (k == 6) after_edge_window("post_reset_win", pack4(1, 2, 5, 6), 0);
        end
        tick(0, 0, 1, 1);

        // Back-to-back frames without idle cycles
        dut_hand = 0;
        done_pulses = 0;
        for (int f = 0; f < 2; f++)
            for (int k = 1; k <= 16; k++) begin
                tick(1, 16'(k), 1, 1);
                if (f == 1 && k == 6) after_edge_window("b2b_first_win", pack4(1, 2, 5, 6), 0);
            end
        tick(0, 0, 1, 1);
        check("b2b_done_pulses", 64'(done_pulses), 64'(2));
        check("b2b_windows", 64'(dut_hand), 64'(18));

        // Randomized traffic with random data, valid, ready and rare resets
        for (int n = 0; n < 400; n++)
            tick($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) != 0);
        for (int n = 0; n < 3; n++) tick(0, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
